// File: rtl/sm_pkg.sv
// ----------------------------------------------------------------------------
// sm_pkg
// Shared definitions for the sign-magnitude accumulator slice:
//   SM_W        - width of a sign-magnitude word (sign + magnitude)
//   SM_MAG_W    - width of the magnitude field
//   SM_MAG_MAX  - largest representable magnitude
//   sm_state_t  - accumulator FSM state encoding
// ----------------------------------------------------------------------------
package sm_pkg;

  localparam int SM_W     = 8;
  localparam int SM_MAG_W = 7;

  localparam logic [SM_MAG_W-1:0] SM_MAG_MAX = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } sm_state_t;

endpackage

// File: rtl/sign_mag_adder.sv
// ----------------------------------------------------------------------------
// sign_mag_adder
// Combinational sign-magnitude adder.
// Ports:
//   a, b : SM_W-bit sign-magnitude operands (bit SM_W-1 = sign)
//   sum  : SM_W+1-bit raw sum {sign, carry, mag[SM_MAG_W-1:0]}
// The carry bit can only be set when both operands share a sign. An exact
// cancellation of opposite-sign operands yields a positive zero; a same-sign
// addition of two zeros keeps the operand sign and is normalised by the user.
// ----------------------------------------------------------------------------
module sign_mag_adder
  import sm_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic [SM_W:0]   sum
);

  logic                a_sgn;
  logic                b_sgn;
  logic [SM_MAG_W-1:0] a_mag;
  logic [SM_MAG_W-1:0] b_mag;
  logic [SM_MAG_W-1:0] diff;

  assign a_sgn = a[SM_W-1];
  assign b_sgn = b[SM_W-1];
  assign a_mag = a[SM_MAG_W-1:0];
  assign b_mag = b[SM_MAG_W-1:0];

  always_comb begin
    sum  = '0;
    diff = '0;
    if (a_sgn == b_sgn) begin
      sum = {a_sgn, {1'b0, a_mag} + {1'b0, b_mag}};
    end else if (a_mag >= b_mag) begin
      diff = a_mag - b_mag;
      sum  = {(diff != '0) ? a_sgn : 1'b0, 1'b0, diff};
    end else begin
      diff = b_mag - a_mag;
      sum  = {b_sgn, 1'b0, diff};
    end
  end

endmodule

// File: rtl/sm_accumulator.sv
// ----------------------------------------------------------------------------
// sm_accumulator
// Sums N_OPS sign-magnitude operands per frame and offers the result on a
// valid/ready handshake.
// Parameters:
//   N_OPS     - operands per frame (1..255)
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   start     - one-cycle pulse that begins a frame (honoured in IDLE only)
//   op_valid  - operand offer
//   op_ready  - operand accept (high in ACC only)
//   op_data   - sign-magnitude operand
//   res_valid - result offer (high in OUT)
//   res_ready - result accept
//   res_data  - sign-magnitude frame sum
//   res_ovf   - sticky: some partial sum magnitude exceeded SM_MAG_MAX
//   busy      - high whenever the FSM is not IDLE
// Build option:
//   SM_ACC_SAT_EN - when defined, an overflowing partial sum clamps to
//                   sign|SM_MAG_MAX; otherwise it wraps modulo 128.
// ----------------------------------------------------------------------------
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int N_OPS = 4
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [SM_W-1:0] op_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SM_W-1:0] res_data,
  output logic            res_ovf,
  output logic            busy
);

  localparam logic [7:0] LAST_CNT = 8'(N_OPS - 1);

  // Fold a raw {sign, carry, mag} sum back into an SM_W-bit word.
  // Any zero magnitude is forced to +0 so 0x80 never reaches the register.
  function automatic logic [SM_W-1:0] fold_sum(input logic [SM_W:0] raw);
    logic [SM_MAG_W-1:0] mag;
`ifdef SM_ACC_SAT_EN
    mag = raw[SM_W-1] ? SM_MAG_MAX : raw[SM_MAG_W-1:0];
`else
    mag = raw[SM_MAG_W-1:0];
`endif
    if (mag == '0) begin
      return '0;
    end
    return {raw[SM_W], mag};
  endfunction

  sm_state_t       state;
  logic [7:0]      cnt;
  logic [SM_W-1:0] acc_p1;
  logic [SM_W:0]   sum_p0;
  logic            xfer_p0;

  // Stage 0: operand transfer and combinational add against the accumulator
  assign xfer_p0 = op_valid & op_ready;

  sign_mag_adder u_adder (
    .a   (acc_p1),
    .b   (op_data),
    .sum (sum_p0)
  );

  // Stage 1: registered accumulator, FSM and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_p1    <= '0;
      res_ovf   <= 1'b0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            cnt      <= '0;
            acc_p1   <= '0;
            res_ovf  <= 1'b0;
            op_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (xfer_p0) begin
            acc_p1 <= fold_sum(sum_p0);
            cnt    <= cnt + 8'd1;
            if (sum_p0[SM_W-1]) begin
              res_ovf <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              state     <= OUT;
              op_ready  <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign res_data = acc_p1;

endmodule

// File: tb/tb_sm_accumulator.sv
// ----------------------------------------------------------------------------
// tb_sm_accumulator
// Self-checking bench for sm_accumulator with N_OPS = 4: a table of directed
// frames, randomized frames against an integer reference model, and
// hand-written sequences for bubbles, result back-pressure and mid-frame reset.
// ----------------------------------------------------------------------------
module tb_sm_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_ovf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  sm_accumulator #(.N_OPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0][7:0] ops;
    logic [7:0]      exp_data;
    logic            exp_ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: accumulate as plain integers, treating any |sum| > 127 as an
  // overflow that either clamps or wraps the magnitude.
  function automatic logic [7:0] model_frame(input logic [3:0][7:0] ops,
                                             output logic ovf);
    int v;
    int s;
    int mag;
    v   = 0;
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s   = v + (ops[i][7] ? -int'(ops[i][6:0]) : int'(ops[i][6:0]));
      mag = (s < 0) ? -s : s;
      if (mag > 127) begin
        ovf = 1'b1;
`ifdef SM_ACC_SAT_EN
        mag = 127;
`else
        mag = mag - 128;
`endif
      end
      v = (s < 0) ? -mag : mag;
    end
    if (v < 0) return {1'b1, 7'(-v)};
    return {1'b0, 7'(v)};
  endfunction

  // One complete frame: start pulse, operands with optional idle gaps, then
  // collect the result and release it.
  task automatic run_frame(input logic [3:0][7:0] ops, input int gap,
                           output logic [7:0] d, output logic o);
    int waited;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1;
      op_data  = ops[i];
      tick();
      op_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    waited = 0;
    while (!res_valid && waited < 10) begin
      tick();
      waited++;
    end
    if (!res_valid) check("res_valid_timeout", 0, 1);
    d = res_data;
    o = res_ovf;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  vec_t            vecs[6];
  logic [7:0]      d;
  logic            o;
  logic [7:0]      exp_d;
  logic            exp_o;
  logic [3:0][7:0] rops;
  logic [7:0]      held;

  initial begin
    vecs[0] = '{"mixed",    {8'h01, 8'h83, 8'h0A, 8'h05}, 8'h0D, 1'b0};
`ifdef SM_ACC_SAT_EN
    vecs[1] = '{"ovf_pos",  {8'h00, 8'h00, 8'h32, 8'h64}, 8'h7F, 1'b1};
    vecs[4] = '{"ovf_neg",  {8'h00, 8'h01, 8'hFF, 8'hFF}, 8'hFE, 1'b1};
    vecs[5] = '{"ovf_mid",  {8'hFF, 8'h7F, 8'h81, 8'h7F}, 8'h00, 1'b1};
`else
    vecs[1] = '{"ovf_pos",  {8'h00, 8'h00, 8'h32, 8'h64}, 8'h16, 1'b1};
    vecs[4] = '{"ovf_neg",  {8'h00, 8'h01, 8'hFF, 8'hFF}, 8'hFD, 1'b1};
    vecs[5] = '{"ovf_mid",  {8'hFF, 8'h7F, 8'h81, 8'h7F}, 8'h82, 1'b1};
`endif
    vecs[2] = '{"cancel",   {8'h00, 8'h80, 8'h07, 8'h87}, 8'h00, 1'b0};
    vecs[3] = '{"neg_zero", {8'h80, 8'h80, 8'h80, 8'h80}, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_op_ready",  int'(op_ready),  0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_res_data",  int'(res_data),  0);
    check("rst_res_ovf",   int'(res_ovf),   0);
    rst_n = 1'b1;
    tick();

    // Directed table
    foreach (vecs[k]) begin
      run_frame(vecs[k].ops, 0, d, o);
      check({vecs[k].name, "_data"}, int'(d), int'(vecs[k].exp_data));
      check({vecs[k].name, "_ovf"},  int'(o), int'(vecs[k].exp_ovf));
      check({vecs[k].name, "_idle"}, int'(busy), 0);
    end

    // Randomized frames against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) rops[i] = 8'($urandom);
      exp_d = model_frame(rops, exp_o);
      run_frame(rops, int'($urandom_range(0, 2)), d, o);
      check($sformatf("rand%0d_data", r), int'(d), int'(exp_d));
      check($sformatf("rand%0d_ovf", r),  int'(o), int'(exp_o));
    end

    // Operand offered with start is not taken; bubbles between transfers
    start = 1'b1; op_valid = 1'b1; op_data = 8'h7F;
    tick();
    start = 1'b0; op_valid = 1'b0;
    check("bub_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1;
      op_data  = 8'(i + 1);
      tick();
      op_valid = 1'b0;
      if (i < 3) begin
        check($sformatf("bub_rv_xfer%0d", i), int'(res_valid), 0);
        for (int g = 0; g < 2; g++) begin
          tick();
          check($sformatf("bub_rv_gap%0d_%0d", i, g), int'(res_valid), 0);
          check($sformatf("bub_data_gap%0d_%0d", i, g), int'(res_data),
                ((i + 1) * (i + 2)) / 2);
        end
      end
    end
    check("bub_res_valid", int'(res_valid), 1);
    check("bub_res_data",  int'(res_data),  8'h0A);

    // Back-pressure on the result with a start pulse in the middle
    held = res_data;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      start = 1'b0;
      check($sformatf("hold%0d_valid", c),    int'(res_valid), 1);
      check($sformatf("hold%0d_data", c),     int'(res_data),  int'(held));
      check($sformatf("hold%0d_op_ready", c), int'(op_ready),  0);
      check($sformatf("hold%0d_busy", c),     int'(busy),      1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release_valid", int'(res_valid), 0);
    check("release_busy",  int'(busy),      0);
    tick();
    check("idle_op_ready", int'(op_ready),  0);
    check("idle_busy",     int'(busy),      0);

    // Reset after two overflowing transfers discards the frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1;
      op_data  = 8'h7F;
      tick();
    end
    op_valid = 1'b0;
    check("pre_rst_ovf", int'(res_ovf), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_op_ready",  int'(op_ready),  0);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_busy",      int'(busy),      0);
    check("mid_rst_res_data",  int'(res_data),  0);
    check("mid_rst_res_ovf",   int'(res_ovf),   0);
    tick();
    check("post_rst_res_valid", int'(res_valid), 0);
    run_frame({8'h01, 8'h01, 8'h01, 8'h01}, 0, d, o);
    check("post_rst_data", int'(d), 8'h04);
    check("post_rst_ovf",  int'(o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_accumulator.md
SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 The block SHALL have one parameter: N_OPS, default 4, giving the operands summed per frame (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a frame.
REQ-005 The block SHALL have port op_valid, input, 1 bit: the operand offer.
REQ-006 The block SHALL have port op_ready, output, 1 bit: operand accept.
REQ-007 The block SHALL have port op_data, input, 8 bits: a sign-magnitude operand, bit 7 = sign, bits 6:0 = magnitude.
REQ-008 The block SHALL have port res_valid, output, 1 bit: the result offer.
REQ-009 The block SHALL have port res_ready, input, 1 bit: result accept.
REQ-010 The block SHALL have port res_data, output, 8 bits: the sign-magnitude frame sum.
REQ-011 The block SHALL have port res_ovf, output, 1 bit: sticky flag, set if any partial sum magnitude exceeded 127.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, ACC and OUT.
REQ-014 In IDLE, start=1 SHALL move the FSM to ACC and, on that edge, clear the accumulator to 0x00, the operand counter to 0 and res_ovf to 0.
REQ-015 In IDLE, op_ready SHALL be 0, so an operand offered in the same cycle as start is not taken.
REQ-016 In ACC, op_ready SHALL be 1, and a transfer SHALL occur on any cycle with op_valid=1 and op_ready=1.
REQ-017 Each transfer SHALL register acc = acc (+) op_data with one cycle of latency, where (+) is 8-bit sign-magnitude addition producing a 9-bit raw sum {sign, carry, mag[6:0]}.
REQ-018 The counter SHALL increment only on a transfer; cycles with op_valid=0 leave the accumulator and counter unchanged.
REQ-019 The transfer that brings the counter to N_OPS SHALL move the FSM to OUT on the same edge.
REQ-020 In OUT, res_valid SHALL be 1, res_data SHALL equal the accumulator and op_ready SHALL be 0.
REQ-021 res_valid, res_data and res_ovf SHALL stay stable until res_ready=1, after which the FSM returns to IDLE on the next edge.
REQ-022 start SHALL be ignored in ACC and OUT.
REQ-023 A zero-magnitude result SHALL always be stored as 0x00, never 0x80.
REQ-024 A raw-sum carry of 1 (magnitude >127) SHALL set res_ovf, and res_ovf SHALL stay set until the next frame start or reset.
REQ-025 With N_OPS=1, a frame SHALL spend exactly one transfer cycle in ACC.

Reset
REQ-026 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the accumulator, counter, res_data and res_ovf SHALL clear to 0.
REQ-027 While rst_n=0 at a clock edge, op_ready, res_valid and busy SHALL be 0.
REQ-028 A reset in the middle of a frame SHALL discard all partial results, with no result emitted.

Configuration
REQ-029 When macro SM_ACC_SAT_EN is defined, a magnitude overflow SHALL clamp the accumulator to sign|0x7F, and later operands SHALL accumulate from the clamped value.
REQ-030 When SM_ACC_SAT_EN is undefined, an overflow SHALL keep mag[6:0] of the raw sum (wrap modulo 128) together with its sign.
REQ-031 res_ovf behaviour SHALL be identical in both builds.

Structure
REQ-032 Shared package sm_pkg SHALL hold the constants SM_W=8 and SM_MAG_W=7, the FSM state encoding, and the magnitude-max constant 7'h7F.
REQ-033 The addition SHALL be performed by one instance of the existing sign_mag_adder sub-module (8-bit inputs, 9-bit sum).
REQ-034 No other sub-module SHALL be used.

Verification
REQ-035 Scenario: N_OPS=4, operands 0x05, 0x0A, 0x83, 0x01 -> res_data=0x0D, res_ovf=0.
REQ-036 Scenario: operands 0x64, 0x32, 0x00, 0x00 -> with SAT_EN res_data=0x7F and res_ovf=1; without SAT_EN res_data=0x16 and res_ovf=1.
REQ-037 Scenario: operands 0x87, 0x07, 0x80, 0x00 -> res_data=0x00, never 0x80.
REQ-038 Scenario: op_valid with 2-cycle bubbles between operands -> the counter advances only on transfers, and res_valid asserts exactly one cycle after the 4th transfer.
REQ-039 Scenario: res_ready held low 5 cycles with start pulsed -> res_data stable, op_ready=0, start ignored, and IDLE entered one cycle after res_ready=1.
REQ-040 Scenario: rst_n low for 1 cycle after 2 transfers -> all outputs 0; the next frame 0x01×4 gives 0x04.
